// File: rtl/syscall_controller_if.sv
// Syscall controller bus: CPU syscall inputs, data-memory read port, output stream.
// The slave modport is the controller; the master modport is its environment.
interface syscall_controller_if;
    logic        syscall;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_int;
    logic [31:0] out_data;
    logic        halt;
    logic        aborted;

    modport slave (
        input  syscall, v0, a0, mem_rdata, mem_rvalid, out_ready,
        output stall, mem_req, mem_addr, out_valid, out_is_int, out_data, halt, aborted
    );

    modport master (
        output syscall, v0, a0, mem_rdata, mem_rvalid, out_ready,
        input  stall, mem_req, mem_addr, out_valid, out_is_int, out_data, halt, aborted
    );
endinterface

// File: rtl/syscall_controller.sv
// Cycle-accurate syscall sequencer: print-int, print-string (streams bytes fetched
// from data memory), and exit (sticky halt). Stalls the pipeline while busy.
module syscall_controller #(
    parameter logic [31:0] MEM_TOP   = 32'h03FF_FFFF,
    parameter logic [31:0] ADDR_BIAS = 32'h7C00_0000,
    parameter int unsigned MAX_CHARS = 4096
) (
    input logic                  clk,
    input logic                  rst_n,
    syscall_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_HALT
    } state_t;

    localparam logic [31:0] SYS_INT  = 32'd1;
    localparam logic [31:0] SYS_STR  = 32'd4;
    localparam logic [31:0] SYS_EXIT = 32'd10;
    localparam logic [31:0] CHAR_LIMIT = 32'(MAX_CHARS);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_ptr;
    logic [31:0] r_count;
    logic [31:0] r_word;
    logic [31:0] r_int_val;
    logic        r_aborted;

    logic        w_sys_known;
    logic [31:0] w_eff_addr;
    logic [7:0]  w_byte;
    logic [31:0] w_ptr_inc;
    logic [31:0] w_count_inc;
    logic        w_limit_hit;
    logic        w_out_valid;
    logic        w_out_is_int;
    logic [31:0] w_out_data;
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_out_fire;

    assign w_sys_known = bus.syscall &&
                         ((bus.v0 == SYS_INT) || (bus.v0 == SYS_STR) || (bus.v0 == SYS_EXIT));

    // Addresses above the direct window are stack/data segment addresses.
    assign w_eff_addr  = (r_ptr > MEM_TOP) ? (r_ptr - ADDR_BIAS) : r_ptr;
    assign w_byte      = r_word[{r_ptr[1:0], 3'b000} +: 8];
    assign w_ptr_inc   = r_ptr + 32'd1;
    assign w_count_inc = r_count + 32'd1;
    assign w_limit_hit = (w_count_inc == CHAR_LIMIT);
    assign w_out_fire  = w_out_valid && bus.out_ready;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_out_valid  = 1'b0;
        w_out_is_int = 1'b0;
        w_out_data   = 32'd0;
        w_mem_req    = 1'b0;
        w_mem_addr   = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (bus.syscall) begin
                    if (bus.v0 == SYS_INT)       w_state_next = S_INT;
                    else if (bus.v0 == SYS_STR)  w_state_next = S_FETCH;
                    else if (bus.v0 == SYS_EXIT) w_state_next = S_HALT;
                end
            end
            S_INT: begin
                w_out_valid  = 1'b1;
                w_out_is_int = 1'b1;
                w_out_data   = r_int_val;
                if (bus.out_ready) w_state_next = S_IDLE;
            end
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_mem_addr   = {w_eff_addr[31:2], 2'b00};
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rvalid) w_state_next = S_EMIT;
            end
            S_EMIT: begin
                if (w_byte == 8'd0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_out_valid = 1'b1;
                    w_out_data  = {24'd0, w_byte};
                    if (bus.out_ready) begin
                        if (w_limit_hit)                 w_state_next = S_IDLE;
                        else if (w_ptr_inc[1:0] == 2'b00) w_state_next = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= 32'd0;
            r_count   <= 32'd0;
            r_word    <= 32'd0;
            r_int_val <= 32'd0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.syscall) begin
                        r_int_val <= bus.a0;
                        r_ptr     <= bus.a0;
                        r_count   <= 32'd0;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) r_word <= bus.mem_rdata;
                end
                S_EMIT: begin
                    if (w_out_fire) begin
                        r_ptr     <= w_ptr_inc;
                        r_count   <= w_count_inc;
                        r_aborted <= w_limit_hit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.stall      = (r_state != S_IDLE) || w_sys_known;
    assign bus.mem_req    = w_mem_req;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_is_int = w_out_is_int;
    assign bus.out_data   = w_out_data;
    assign bus.halt       = (r_state == S_HALT);
    assign bus.aborted    = r_aborted;

endmodule
